// File: rtl/idex_operand_stage.sv
// ID/EX operand stage: single-entry pipeline register with MEM/WB forwarding,
// load-use stall and flush, feeding the ALU through a valid/ready handshake.
package idex_operand_stage_pkg;
  typedef enum logic [3:0] {
    ALU_ADD, ALU_SUB, ALU_SLL, ALU_SLT, ALU_SLTU,
    ALU_XOR, ALU_SRL, ALU_SRA, ALU_OR, ALU_AND
  } alu_ops_t;
endpackage

module idex_operand_stage
  import idex_operand_stage_pkg::*;
#(
  parameter int XLEN   = 32,
  parameter bit FWD_EN = 1'b1
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            id_valid,
  output logic            id_ready,
  input  logic [XLEN-1:0] id_pc,
  input  logic [4:0]      id_rs1_addr,
  input  logic [4:0]      id_rs2_addr,
  input  logic [XLEN-1:0] id_rs1_data,
  input  logic [XLEN-1:0] id_rs2_data,
  input  logic [XLEN-1:0] id_imm,
  input  logic            id_use_pc,
  input  logic            id_use_imm,
  input  alu_ops_t        id_alu_op,
  input  logic [4:0]      id_rd_addr,
  input  logic            id_reg_write,
  input  logic            mem_rd_valid,
  input  logic            mem_rd_pending,
  input  logic [4:0]      mem_rd_addr,
  input  logic [XLEN-1:0] mem_rd_data,
  input  logic            wb_rd_valid,
  input  logic [4:0]      wb_rd_addr,
  input  logic [XLEN-1:0] wb_rd_data,
  input  logic            flush,
  output logic            ex_valid,
  input  logic            ex_ready,
  output logic [XLEN-1:0] ex_operand_a,
  output logic [XLEN-1:0] ex_operand_b,
  output alu_ops_t        ex_alu_op,
  output logic [XLEN-1:0] ex_store_data,
  output logic [XLEN-1:0] ex_pc,
  output logic [4:0]      ex_rd_addr,
  output logic            ex_reg_write,
  output logic            hazard_stall
);

  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] rs1_data;
    logic [XLEN-1:0] rs2_data;
    logic [XLEN-1:0] imm;
    logic [4:0]      rs1_addr;
    logic [4:0]      rs2_addr;
    logic [4:0]      rd_addr;
    logic            use_pc;
    logic            use_imm;
    logic            reg_write;
    alu_ops_t        alu_op;
  } entry_t;

  entry_t          ent_q;
  logic            valid_q;
  logic            mem_hit1, mem_hit2, wb_hit1, wb_hit2;
  logic [XLEN-1:0] fwd1, fwd2;
  logic            pend_hit, any_hit;
  logic            ex_fire, capture;

  // x0 never hits: it reads as zero regardless of in-flight writers
  assign mem_hit1 = mem_rd_valid && (mem_rd_addr == ent_q.rs1_addr) && (ent_q.rs1_addr != 5'd0);
  assign mem_hit2 = mem_rd_valid && (mem_rd_addr == ent_q.rs2_addr) && (ent_q.rs2_addr != 5'd0);
  assign wb_hit1  = wb_rd_valid  && (wb_rd_addr  == ent_q.rs1_addr) && (ent_q.rs1_addr != 5'd0);
  assign wb_hit2  = wb_rd_valid  && (wb_rd_addr  == ent_q.rs2_addr) && (ent_q.rs2_addr != 5'd0);

  assign fwd1 = (ent_q.rs1_addr == 5'd0) ? '0 :
                mem_hit1 ? mem_rd_data : wb_hit1 ? wb_rd_data : ent_q.rs1_data;
  assign fwd2 = (ent_q.rs2_addr == 5'd0) ? '0 :
                mem_hit2 ? mem_rd_data : wb_hit2 ? wb_rd_data : ent_q.rs2_data;

  // rs1 is dead when operand_a takes the PC; rs2 is always live as store data
  assign pend_hit = mem_rd_pending && ((!ent_q.use_pc && mem_hit1) || mem_hit2);
  assign any_hit  = (!ent_q.use_pc && (mem_hit1 || wb_hit1)) || mem_hit2 || wb_hit2;

  assign hazard_stall = valid_q && (FWD_EN ? pend_hit : any_hit);
  assign ex_valid     = valid_q && !hazard_stall;
  assign ex_fire      = ex_valid && ex_ready;
  assign id_ready     = !valid_q || ex_fire || flush;
  assign capture      = id_valid && id_ready && !flush;

  assign ex_operand_a  = ent_q.use_pc  ? ent_q.pc  : fwd1;
  assign ex_operand_b  = ent_q.use_imm ? ent_q.imm : fwd2;
  assign ex_store_data = fwd2;
  assign ex_alu_op     = ent_q.alu_op;
  assign ex_pc         = ent_q.pc;
  assign ex_rd_addr    = ent_q.rd_addr;
  assign ex_reg_write  = ent_q.reg_write && ex_valid;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q <= 1'b0;
      ent_q   <= '0;
    end else if (flush) begin
      valid_q <= 1'b0;
    end else if (capture) begin
      valid_q         <= 1'b1;
      ent_q.pc        <= id_pc;
      ent_q.rs1_data  <= id_rs1_data;
      ent_q.rs2_data  <= id_rs2_data;
      ent_q.imm       <= id_imm;
      ent_q.rs1_addr  <= id_rs1_addr;
      ent_q.rs2_addr  <= id_rs2_addr;
      ent_q.rd_addr   <= id_rd_addr;
      ent_q.use_pc    <= id_use_pc;
      ent_q.use_imm   <= id_use_imm;
      ent_q.reg_write <= id_reg_write;
      ent_q.alu_op    <= id_alu_op;
    end else if (ex_fire) begin
      valid_q <= 1'b0;
    end else if (valid_q) begin
      // keep results that retire past WB while this entry waits
      ent_q.rs1_data <= fwd1;
      ent_q.rs2_data <= fwd2;
    end
  end

endmodule

// File: tb/tb_idex_operand_stage.sv
// Scoreboard bench for idex_operand_stage: expected EX beats are queued at
// issue and compared when the stage hands them to EX.
module tb_idex_operand_stage;
  import idex_operand_stage_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        id_valid, id_ready;
  logic [31:0] id_pc, id_rs1_data, id_rs2_data, id_imm;
  logic [4:0]  id_rs1_addr, id_rs2_addr, id_rd_addr;
  logic        id_use_pc, id_use_imm, id_reg_write;
  alu_ops_t    id_alu_op;
  logic        mem_rd_valid, mem_rd_pending, wb_rd_valid;
  logic [4:0]  mem_rd_addr, wb_rd_addr;
  logic [31:0] mem_rd_data, wb_rd_data;
  logic        flush;
  logic        ex_valid, ex_ready;
  logic [31:0] ex_operand_a, ex_operand_b, ex_store_data, ex_pc;
  alu_ops_t    ex_alu_op;
  logic [4:0]  ex_rd_addr;
  logic        ex_reg_write, hazard_stall;

  typedef struct {
    logic [31:0] a, b, st, pc;
    logic [4:0]  rd;
    logic        rw;
    alu_ops_t    op;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;

  idex_operand_stage #(.XLEN(32), .FWD_EN(1'b1)) dut (
    .clk(clk), .rst_n(rst_n),
    .id_valid(id_valid), .id_ready(id_ready), .id_pc(id_pc),
    .id_rs1_addr(id_rs1_addr), .id_rs2_addr(id_rs2_addr),
    .id_rs1_data(id_rs1_data), .id_rs2_data(id_rs2_data), .id_imm(id_imm),
    .id_use_pc(id_use_pc), .id_use_imm(id_use_imm), .id_alu_op(id_alu_op),
    .id_rd_addr(id_rd_addr), .id_reg_write(id_reg_write),
    .mem_rd_valid(mem_rd_valid), .mem_rd_pending(mem_rd_pending),
    .mem_rd_addr(mem_rd_addr), .mem_rd_data(mem_rd_data),
    .wb_rd_valid(wb_rd_valid), .wb_rd_addr(wb_rd_addr), .wb_rd_data(wb_rd_data),
    .flush(flush), .ex_valid(ex_valid), .ex_ready(ex_ready),
    .ex_operand_a(ex_operand_a), .ex_operand_b(ex_operand_b),
    .ex_alu_op(ex_alu_op), .ex_store_data(ex_store_data), .ex_pc(ex_pc),
    .ex_rd_addr(ex_rd_addr), .ex_reg_write(ex_reg_write),
    .hazard_stall(hazard_stall)
  );

  always #5 clk = ~clk;

  // Scoreboard: every beat EX accepts must match the oldest expected entry
  always @(negedge clk) begin
    if (rst_n && ex_valid && ex_ready) begin
      checks++;
      if (sb.size() == 0) begin
        errors++;
        $display("FAIL unexpected_beat pc=%h a=%h b=%h", ex_pc, ex_operand_a, ex_operand_b);
      end else begin
        exp_t e;
        e = sb.pop_front();
        if ({ex_operand_a, ex_operand_b, ex_store_data, ex_pc, ex_rd_addr, ex_reg_write, ex_alu_op}
            !== {e.a, e.b, e.st, e.pc, e.rd, e.rw, e.op}) begin
          errors++;
          $display("FAIL ex_beat got a=%h b=%h st=%h pc=%h rd=%0d rw=%b op=%0d want a=%h b=%h st=%h pc=%h rd=%0d rw=%b op=%0d",
                   ex_operand_a, ex_operand_b, ex_store_data, ex_pc, ex_rd_addr, ex_reg_write, ex_alu_op,
                   e.a, e.b, e.st, e.pc, e.rd, e.rw, e.op);
        end
      end
    end
  end

  task automatic drive_id(input logic [31:0] pc, input logic [4:0] rs1, input logic [4:0] rs2,
                          input logic [31:0] d1, input logic [31:0] d2, input logic [31:0] imm,
                          input logic upc, input logic uimm, input alu_ops_t op,
                          input logic [4:0] rd, input logic rw);
    id_pc = pc; id_rs1_addr = rs1; id_rs2_addr = rs2; id_rs1_data = d1; id_rs2_data = d2;
    id_imm = imm; id_use_pc = upc; id_use_imm = uimm; id_alu_op = op;
    id_rd_addr = rd; id_reg_write = rw;
  endtask

  // Issue one beat (called just after a rising edge) and queue its expected EX view
  task automatic send(input logic [31:0] pc, input logic [4:0] rs1, input logic [4:0] rs2,
                      input logic [31:0] d1, input logic [31:0] d2, input logic [31:0] imm,
                      input logic upc, input logic uimm, input alu_ops_t op,
                      input logic [4:0] rd, input logic rw,
                      input logic [31:0] ea, input logic [31:0] eb, input logic [31:0] est);
    exp_t e;
    bit   ok = 0;
    drive_id(pc, rs1, rs2, d1, d2, imm, upc, uimm, op, rd, rw);
    id_valid = 1'b1;
    for (int n = 0; n < 50; n++) begin
      @(negedge clk);
      if (id_ready) begin ok = 1; break; end
    end
    if (!ok) begin
      checks++; errors++;
      $display("FAIL send_timeout pc=%h id_ready=%b required 1", pc, id_ready);
    end else begin
      e.a = ea; e.b = eb; e.st = est; e.pc = pc; e.rd = rd; e.rw = rw; e.op = op;
      sb.push_back(e);
    end
    @(posedge clk); #1;
    id_valid = 1'b0;
  endtask

  task automatic test_reset;
    #1;
    checks++;
    if ({ex_valid, id_ready, hazard_stall, ex_reg_write, ex_alu_op, ex_operand_a, ex_operand_b}
        !== {1'b0, 1'b1, 1'b0, 1'b0, ALU_ADD, 32'h0, 32'h0}) begin
      errors++;
      $display("FAIL reset_state got v=%b rdy=%b hz=%b rw=%b op=%0d a=%h b=%h required 0 1 0 0 0 0 0",
               ex_valid, id_ready, hazard_stall, ex_reg_write, ex_alu_op, ex_operand_a, ex_operand_b);
    end
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
  endtask

  task automatic test_basic;
    ex_ready = 1'b1;
    send(32'h0000_0040, 5'd1, 5'd2, 32'd5, 32'd7, 32'h0, 1'b0, 1'b0, ALU_ADD, 5'd3, 1'b1,
         32'd5, 32'd7, 32'd7);
    @(negedge clk);
    checks++;
    if ({ex_valid, ex_operand_a, ex_operand_b, ex_alu_op} !== {1'b1, 32'd5, 32'd7, ALU_ADD}) begin
      errors++;
      $display("FAIL basic_latency got v=%b a=%h b=%h op=%0d required v=1 a=5 b=7 op=0",
               ex_valid, ex_operand_a, ex_operand_b, ex_alu_op);
    end
    @(negedge clk);
    checks++;
    if (ex_valid !== 1'b0) begin
      errors++;
      $display("FAIL basic_drain got ex_valid=%b required 0", ex_valid);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_forward;
    ex_ready = 1'b1;
    mem_rd_valid = 1'b1; mem_rd_addr = 5'd1; mem_rd_data = 32'h10;
    wb_rd_valid  = 1'b1; wb_rd_addr  = 5'd1; wb_rd_data  = 32'h20;
    send(32'h100, 5'd1, 5'd0, 32'h99, 32'h55, 32'h0, 1'b0, 1'b0, ALU_XOR, 5'd4, 1'b1,
         32'h10, 32'h0, 32'h0);
    @(negedge clk);
    checks++;
    if ({ex_operand_a, ex_operand_b} !== {32'h10, 32'h0}) begin
      errors++;
      $display("FAIL fwd_mem_prio got a=%h b=%h required a=10 b=0", ex_operand_a, ex_operand_b);
    end
    @(posedge clk); #1;
    mem_rd_addr = 5'd5; mem_rd_data = 32'h30;
    send(32'h104, 5'd5, 5'd1, 32'h1, 32'h2, 32'h0, 1'b0, 1'b0, ALU_SUB, 5'd6, 1'b0,
         32'h30, 32'h20, 32'h20);
    @(posedge clk); #1;
    send(32'h400, 5'd5, 5'd1, 32'h1, 32'h2, 32'hFFFF_FFF0, 1'b1, 1'b1, ALU_ADD, 5'd0, 1'b1,
         32'h400, 32'hFFFF_FFF0, 32'h20);
    @(posedge clk); #1;
    mem_rd_valid = 1'b0; wb_rd_valid = 1'b0;
  endtask

  task automatic test_load_use;
    ex_ready = 1'b1;
    mem_rd_valid = 1'b1; mem_rd_pending = 1'b1; mem_rd_addr = 5'd2; mem_rd_data = 32'hDEAD;
    send(32'h200, 5'd4, 5'd2, 32'd1, 32'd0, 32'h0, 1'b0, 1'b0, ALU_AND, 5'd6, 1'b1,
         32'd1, 32'h1234, 32'h1234);
    repeat (3) begin
      @(negedge clk);
      checks++;
      if ({hazard_stall, ex_valid, ex_reg_write} !== 3'b100) begin
        errors++;
        $display("FAIL load_use_stall got hz=%b v=%b rw=%b required 1 0 0",
                 hazard_stall, ex_valid, ex_reg_write);
      end
    end
    @(posedge clk); #1;
    ex_ready = 1'b0; mem_rd_pending = 1'b0; mem_rd_data = 32'h1234;
    @(negedge clk);
    checks++;
    if ({hazard_stall, ex_valid, ex_operand_b} !== {1'b0, 1'b1, 32'h1234}) begin
      errors++;
      $display("FAIL load_use_release got hz=%b v=%b b=%h required 0 1 1234",
               hazard_stall, ex_valid, ex_operand_b);
    end
    @(posedge clk); #1;
    mem_rd_valid = 1'b0; wb_rd_valid = 1'b1; wb_rd_addr = 5'd2; wb_rd_data = 32'h1234;
    @(posedge clk); #1;
    wb_rd_valid = 1'b0;
    @(negedge clk);
    checks++;
    if (ex_operand_b !== 32'h1234) begin
      errors++;
      $display("FAIL load_use_retain got b=%h required 1234", ex_operand_b);
    end
    @(posedge clk); #1;
    ex_ready = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_backpressure;
    exp_t e;
    ex_ready = 1'b0;
    send(32'h300, 5'd7, 5'd8, 32'd11, 32'd22, 32'h0, 1'b0, 1'b0, ALU_OR, 5'd9, 1'b1,
         32'd11, 32'd22, 32'd22);
    drive_id(32'h304, 5'd9, 5'd10, 32'd33, 32'd44, 32'h0, 1'b0, 1'b0, ALU_SLT, 5'd11, 1'b1);
    id_valid = 1'b1;
    repeat (3) begin
      @(negedge clk);
      checks++;
      if ({id_ready, ex_valid, ex_operand_a, ex_operand_b, ex_pc} !== {1'b0, 1'b1, 32'd11, 32'd22, 32'h300}) begin
        errors++;
        $display("FAIL backpressure_hold got rdy=%b v=%b a=%h b=%h pc=%h required 0 1 b 16 300",
                 id_ready, ex_valid, ex_operand_a, ex_operand_b, ex_pc);
      end
    end
    @(posedge clk); #1;
    ex_ready = 1'b1;
    e.a = 32'd33; e.b = 32'd44; e.st = 32'd44; e.pc = 32'h304; e.rd = 5'd11; e.rw = 1'b1; e.op = ALU_SLT;
    sb.push_back(e);
    @(negedge clk);
    checks++;
    if (id_ready !== 1'b1) begin
      errors++;
      $display("FAIL backpressure_release got id_ready=%b required 1", id_ready);
    end
    @(posedge clk); #1;
    id_valid = 1'b0;
    @(negedge clk);
    checks++;
    if ({ex_valid, ex_pc} !== {1'b1, 32'h304}) begin
      errors++;
      $display("FAIL replace_no_bubble got v=%b pc=%h required 1 304", ex_valid, ex_pc);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_back_to_back;
    ex_ready = 1'b1;
    for (int i = 0; i < 6; i++) begin
      logic [31:0] pc, d1, d2, imm;
      logic [4:0]  r1, r2;
      logic        upc, uimm;
      pc = 32'h1000 + 32'(i * 4); d1 = $urandom; d2 = $urandom; imm = $urandom;
      r1 = 5'($urandom_range(1, 31)); r2 = 5'($urandom_range(1, 31));
      upc = i[0]; uimm = i[1];
      send(pc, r1, r2, d1, d2, imm, upc, uimm, alu_ops_t'(i % 10), 5'(i + 1), i[2],
           upc ? pc : d1, uimm ? imm : d2, d2);
    end
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL back_to_back_drain got pending=%0d required 0", sb.size());
    end
  endtask

  task automatic test_flush;
    ex_ready = 1'b0;
    send(32'h500, 5'd1, 5'd2, 32'd1, 32'd2, 32'h0, 1'b0, 1'b0, ALU_SRA, 5'd3, 1'b1,
         32'd1, 32'd2, 32'd2);
    drive_id(32'h504, 5'd3, 5'd4, 32'd5, 32'd6, 32'h0, 1'b0, 1'b0, ALU_SLL, 5'd7, 1'b1);
    id_valid = 1'b1; flush = 1'b1;
    @(negedge clk);
    checks++;
    if (id_ready !== 1'b1) begin
      errors++;
      $display("FAIL flush_ready got id_ready=%b required 1", id_ready);
    end
    @(posedge clk); #1;
    flush = 1'b0; id_valid = 1'b0;
    sb.delete();
    ex_ready = 1'b1;
    @(negedge clk);
    checks++;
    if ({ex_valid, ex_reg_write} !== 2'b00) begin
      errors++;
      $display("FAIL flush_kill got v=%b rw=%b required 0 0", ex_valid, ex_reg_write);
    end
    repeat (2) @(posedge clk);
    #1;
  endtask

  task automatic test_reset_mid;
    ex_ready = 1'b0;
    send(32'h600, 5'd1, 5'd2, 32'd9, 32'd8, 32'h0, 1'b0, 1'b0, ALU_SUB, 5'd3, 1'b1,
         32'd9, 32'd8, 32'd8);
    id_valid = 1'b1;
    @(negedge clk);
    #1 rst_n = 1'b0;
    #1;
    checks++;
    if ({ex_valid, id_ready, ex_alu_op, ex_reg_write} !== {1'b0, 1'b1, ALU_ADD, 1'b0}) begin
      errors++;
      $display("FAIL reset_mid got v=%b rdy=%b op=%0d rw=%b required 0 1 0 0",
               ex_valid, id_ready, ex_alu_op, ex_reg_write);
    end
    sb.delete();
    id_valid = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
  endtask

  initial begin
    rst_n = 1'b0; id_valid = 1'b0; flush = 1'b0; ex_ready = 1'b0;
    drive_id(32'h0, 5'd0, 5'd0, 32'h0, 32'h0, 32'h0, 1'b0, 1'b0, ALU_ADD, 5'd0, 1'b0);
    mem_rd_valid = 1'b0; mem_rd_pending = 1'b0; mem_rd_addr = 5'd0; mem_rd_data = 32'h0;
    wb_rd_valid = 1'b0; wb_rd_addr = 5'd0; wb_rd_data = 32'h0;
    test_reset();
    test_basic();
    test_forward();
    test_load_use();
    test_backpressure();
    test_back_to_back();
    test_flush();
    test_reset_mid();
    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL final_drain got pending=%0d required 0", sb.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
